mem_bist_ctrl: RTL and testbench
================================

MEM_BIST_CTRL -- requirements
Module: mem_bist_ctrl

Interface
REQ-001 SHALL have parameter DW, default 8, RAM data width.
REQ-002 SHALL have parameter AW, default 4, RAM address width (depth 2**AW = 16).
REQ-003 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port start  input  1  one-cycle request to run the test.
REQ-006 SHALL have port pattern  input  DW  background data, captured when start is accepted.
REQ-007 SHALL have port we  output  1  RAM write enable.
REQ-008 SHALL have port re  output  1  RAM read enable.
REQ-009 SHALL have port wr_addr  output  AW  RAM write address.
REQ-010 SHALL have port rd_addr  output  AW  RAM read address.
REQ-011 SHALL have port din  output  DW  RAM write data.
REQ-012 SHALL have port dout  input  DW  RAM read data, valid one cycle after re sampled high.
REQ-013 SHALL have port busy  output  1  test in progress.
REQ-014 SHALL have port done  output  1  one-cycle pulse at test end.
REQ-015 SHALL have port pass  output  1  last completed test had zero mismatches, held until next start.
REQ-016 SHALL have port err_count  output  AW+2  number of mismatches in current/last test.
REQ-017 SHALL have port fail_addr  output  AW  address of first mismatch, 0 if none.

Function
REQ-018 SHALL use states IDLE, W0, R1, W1, R2, DRAIN, DONE.
REQ-019 IDLE: start=1 -> W0, capture P=pattern, clear err_count, fail_addr, pass, first-fail flag; busy=1 from next cycle.
REQ-020 W0: we=1, din=P, wr_addr ascending 0..15, one per cycle; after addr 15 -> R1 at addr 0.
REQ-021 R1: re=1, rd_addr=a, expected=P; next cycle W1: we=1, wr_addr=a, din=~P; W1 -> R1 at a+1, after a=15 -> R2 at addr 15.
REQ-022 R2: re=1, rd_addr descending 15..0, expected=~P, one per cycle; after addr 0 -> DRAIN.
REQ-023 DRAIN: no RAM access, compares final read -> DONE; DONE: done=1, busy=0, pass=(err_count==0) -> IDLE.
REQ-024 Compare: dout checked against expected registered one cycle after each re; mismatch increments err_count; first mismatch loads fail_addr.
REQ-025 Latency: start sampled at edge 0 -> W0 cycles 1-16, R1/W1 17-48, R2 49-64, DRAIN 65, done=1 in cycle 66.
REQ-026 we and re SHALL never be high in the same cycle; both 0 in IDLE, DRAIN, DONE.
REQ-027 start while busy or in DONE SHALL be ignored; pattern changes after capture have no effect.
REQ-028 err_count max 32 (32 compares), no wrap; outputs we/re/addr/din held 0 when inactive.

Reset
REQ-029 rst=0 SHALL immediately force IDLE and we=re=0, wr_addr=rd_addr=0, din=0, busy=done=pass=0, err_count=0, fail_addr=0, including mid-test.
REQ-030 After release, first start SHALL run a complete test from W0.

Structure
REQ-031 mem_bist_pkg SHALL hold the state enum and default DW/AW constants.
REQ-032 Compare pipeline (expected-data register, mismatch, counter, first-fail capture) SHALL be sub-module mem_bist_chk.

Verification
REQ-033 Ideal 16x8 RAM model, pattern 8'hA5 -> done in cycle 66, pass=1, err_count=0, 16 writes of A5 then 16 of 5A observed.
REQ-034 Addr 4 bit0 stuck-at-1, pattern 8'h00 -> err_count=1, fail_addr=4, pass=0.
REQ-035 Coupling fault (write to 3 also writes 12), pattern 8'h5A -> err_count=1, fail_addr=12, pass=0.
REQ-036 start pulsed at cycles 10 and 40 of a run -> ignored, done still in cycle 66, single run.
REQ-037 rst low during R1 (cycle 30) -> all outputs 0 asynchronously; new start -> full passing run.
REQ-038 Assertion over all runs: never we&&re; done only one cycle; busy=0 in IDLE.

Source files
------------

// File: rtl/mem_bist_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// mem_bist_pkg
// Purpose : shared types and default sizes for the memory BIST controller.
// Contents: DEF_DW / DEF_AW default RAM data/address widths, state_t enum of
//           the March-style test sequencer.
// ----------------------------------------------------------------------------
package mem_bist_pkg;

  localparam int DEF_DW = 8;
  localparam int DEF_AW = 4;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    W0    = 3'd1,
    R1    = 3'd2,
    W1    = 3'd3,
    R2    = 3'd4,
    DRAIN = 3'd5,
    DONE  = 3'd6
  } state_t;

endpackage

// File: rtl/mem_bist_ctrl_if.sv
// ----------------------------------------------------------------------------
// mem_bist_ctrl_if
// Purpose : RAM-side bus between the BIST controller and the RAM under test.
// Signals : we/wr_addr/din  write port (driven by the controller)
//           re/rd_addr      read request (driven by the controller)
//           dout            read data, valid one cycle after re is sampled
// Modports: master = BIST controller, slave = RAM.
// ----------------------------------------------------------------------------
interface mem_bist_ctrl_if
  import mem_bist_pkg::*;
#(
  parameter int DW = DEF_DW,
  parameter int AW = DEF_AW
);

  logic          we;
  logic          re;
  logic [AW-1:0] wr_addr;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] din;
  logic [DW-1:0] dout;

  modport master (
    output we, re, wr_addr, rd_addr, din,
    input  dout
  );

  modport slave (
    input  we, re, wr_addr, rd_addr, din,
    output dout
  );

endinterface

// File: rtl/mem_bist_ctrl_chk.sv
// ----------------------------------------------------------------------------
// mem_bist_chk
// Purpose : read-compare pipeline of the BIST. Captures the expected data and
//           address alongside each read request, compares against RAM data
//           one cycle later, counts mismatches and records the first failing
//           address.
// Ports   : clk, rst (async, active-low)
//           i_clear        start of a new test: clears all results
//           i_re/i_rd_addr/i_exp  read request issued this cycle + expectation
//           i_dout         RAM read data
//           o_err_count    mismatch count (saturating)
//           o_fail_addr    address of first mismatch, 0 if none
//           o_clean        no mismatch so far including the compare this cycle
// ----------------------------------------------------------------------------
module mem_bist_chk
  import mem_bist_pkg::*;
#(
  parameter int DW = DEF_DW,
  parameter int AW = DEF_AW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_clear,
  input  logic          i_re,
  input  logic [AW-1:0] i_rd_addr,
  input  logic [DW-1:0] i_exp,
  input  logic [DW-1:0] i_dout,
  output logic [AW+1:0] o_err_count,
  output logic [AW-1:0] o_fail_addr,
  output logic          o_clean
);

  // Two read passes over the whole array bound the count.
  localparam logic [AW+1:0] ERR_MAX = (AW+2)'(2 ** (AW + 1));

  logic          r_exp_vld;
  logic [DW-1:0] r_exp;
  logic [AW-1:0] r_exp_addr;
  logic [AW+1:0] r_err_count;
  logic [AW-1:0] r_fail_addr;
  logic          r_failed;
  logic          w_mismatch;

  assign w_mismatch  = r_exp_vld && (i_dout != r_exp);
  // Lets the controller latch pass on the same edge as the final compare.
  assign o_clean     = (r_err_count == '0) && !w_mismatch;
  assign o_err_count = r_err_count;
  assign o_fail_addr = r_fail_addr;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_exp_vld   <= 1'b0;
      r_exp       <= '0;
      r_exp_addr  <= '0;
      r_err_count <= '0;
      r_fail_addr <= '0;
      r_failed    <= 1'b0;
    end else if (i_clear) begin
      r_exp_vld   <= 1'b0;
      r_exp       <= '0;
      r_exp_addr  <= '0;
      r_err_count <= '0;
      r_fail_addr <= '0;
      r_failed    <= 1'b0;
    end else begin
      r_exp_vld  <= i_re;
      r_exp      <= i_exp;
      r_exp_addr <= i_rd_addr;
      if (w_mismatch) begin
        if (r_err_count != ERR_MAX) begin
          r_err_count <= r_err_count + 1'b1;
        end
        if (!r_failed) begin
          r_failed    <= 1'b1;
          r_fail_addr <= r_exp_addr;
        end
      end
    end
  end

endmodule

// File: rtl/mem_bist_ctrl.sv
// ----------------------------------------------------------------------------
// mem_bist_ctrl
// Purpose : March-style RAM self test. Writes background P ascending, then
//           ascending read-P / write-~P pairs, then descending read-~P, and
//           reports mismatch count, first failing address and pass/fail.
// Ports   : clk, rst (async, active-low)
//           start/pattern   one-cycle test request, background data
//           ram             RAM bus (mem_bist_ctrl_if master)
//           busy/done/pass  status; done is a one-cycle pulse
//           err_count/fail_addr  results of the current/last test
// ----------------------------------------------------------------------------
module mem_bist_ctrl
  import mem_bist_pkg::*;
#(
  parameter int DW = DEF_DW,
  parameter int AW = DEF_AW
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [DW-1:0]        pattern,
  mem_bist_ctrl_if.master      ram,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [AW+1:0]        err_count,
  output logic [AW-1:0]        fail_addr
);

  localparam logic [AW-1:0] ADDR_MAX = {AW{1'b1}};

  state_t        r_state;
  logic [DW-1:0] r_pat;
  logic [AW-1:0] r_addr;
  logic          r_we;
  logic          r_re;
  logic [AW-1:0] r_wr_addr;
  logic [AW-1:0] r_rd_addr;
  logic [DW-1:0] r_din;
  logic [DW-1:0] r_exp;
  logic          r_busy;
  logic          r_done;
  logic          r_pass;
  logic          w_clear;
  logic          w_clean;

  assign w_clear = (r_state == IDLE) && start;

  // All RAM-side and status outputs come straight from registers; the
  // per-state defaults below keep the bus at 0 whenever it is inactive.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= IDLE;
      r_pat     <= '0;
      r_addr    <= '0;
      r_we      <= 1'b0;
      r_re      <= 1'b0;
      r_wr_addr <= '0;
      r_rd_addr <= '0;
      r_din     <= '0;
      r_exp     <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_pass    <= 1'b0;
    end else begin
      r_we      <= 1'b0;
      r_re      <= 1'b0;
      r_wr_addr <= '0;
      r_rd_addr <= '0;
      r_din     <= '0;
      r_exp     <= '0;
      r_done    <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_state   <= W0;
            r_pat     <= pattern;
            r_pass    <= 1'b0;
            r_busy    <= 1'b1;
            r_addr    <= '0;
            r_we      <= 1'b1;
            r_din     <= pattern;
          end
        end
        W0: begin
          if (r_addr == ADDR_MAX) begin
            r_state <= R1;
            r_addr  <= '0;
            r_re    <= 1'b1;
            r_exp   <= r_pat;
          end else begin
            r_addr    <= r_addr + 1'b1;
            r_we      <= 1'b1;
            r_wr_addr <= r_addr + 1'b1;
            r_din     <= r_pat;
          end
        end
        R1: begin
          r_state   <= W1;
          r_we      <= 1'b1;
          r_wr_addr <= r_addr;
          r_din     <= ~r_pat;
        end
        W1: begin
          if (r_addr == ADDR_MAX) begin
            r_state   <= R2;
            r_re      <= 1'b1;
            r_rd_addr <= ADDR_MAX;
            r_exp     <= ~r_pat;
          end else begin
            r_state   <= R1;
            r_addr    <= r_addr + 1'b1;
            r_re      <= 1'b1;
            r_rd_addr <= r_addr + 1'b1;
            r_exp     <= r_pat;
          end
        end
        R2: begin
          if (r_addr == '0) begin
            r_state <= DRAIN;
          end else begin
            r_addr    <= r_addr - 1'b1;
            r_re      <= 1'b1;
            r_rd_addr <= r_addr - 1'b1;
            r_exp     <= ~r_pat;
          end
        end
        DRAIN: begin
          // The last read is compared on this edge, so use the look-ahead.
          r_state <= DONE;
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_pass  <= w_clean;
        end
        DONE: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  mem_bist_chk #(
    .DW (DW),
    .AW (AW)
  ) u_chk (
    .clk         (clk),
    .rst         (rst),
    .i_clear     (w_clear),
    .i_re        (r_re),
    .i_rd_addr   (r_rd_addr),
    .i_exp       (r_exp),
    .i_dout      (ram.dout),
    .o_err_count (err_count),
    .o_fail_addr (fail_addr),
    .o_clean     (w_clean)
  );

  assign ram.we      = r_we;
  assign ram.re      = r_re;
  assign ram.wr_addr = r_wr_addr;
  assign ram.rd_addr = r_rd_addr;
  assign ram.din     = r_din;
  assign busy        = r_busy;
  assign done        = r_done;
  assign pass        = r_pass;

endmodule

// File: tb/tb_mem_bist_ctrl.sv
// ----------------------------------------------------------------------------
// tb_mem_bist_ctrl
// Purpose : bench for mem_bist_ctrl with a 16x8 RAM model that can carry a
//           stuck-at or coupling fault; expected results come from a plain
//           software run of the March sequence over an array.
// ----------------------------------------------------------------------------
module tb_mem_bist_ctrl;
  import mem_bist_pkg::*;

  localparam int DW    = 8;
  localparam int AW    = 4;
  localparam int DEPTH = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic [DW-1:0] pattern = '0;
  logic          busy, done, pass;
  logic [AW+1:0] err_count;
  logic [AW-1:0] fail_addr;

  int n_checks = 0;
  int n_errors = 0;

  // fault_kind: 0 none, 1 stuck-at-1, 2 stuck-at-0, 3 coupling src->dst
  int f_kind = 0;
  int f_addr = 0;
  int f_bit  = 0;
  int f_src  = 0;
  int f_dst  = 0;

  logic [DW-1:0] mem [DEPTH];

  mem_bist_ctrl_if #(.DW(DW), .AW(AW)) ram_if ();

  mem_bist_ctrl #(.DW(DW), .AW(AW)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .pattern   (pattern),
    .ram       (ram_if),
    .busy      (busy),
    .done      (done),
    .pass      (pass),
    .err_count (err_count),
    .fail_addr (fail_addr)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] fault_rd(input int a, input logic [DW-1:0] d);
    logic [DW-1:0] m;
    m = 8'(1) << f_bit;
    if (f_kind == 1 && a == f_addr) return d | m;
    if (f_kind == 2 && a == f_addr) return d & ~m;
    return d;
  endfunction

  initial begin
    for (int i = 0; i < DEPTH; i++) mem[i] = 8'h00;
    ram_if.dout = '0;
  end

  always @(posedge clk) begin
    if (ram_if.we) begin
      mem[ram_if.wr_addr] <= ram_if.din;
      if (f_kind == 3 && int'(ram_if.wr_addr) == f_src) mem[f_dst] <= ram_if.din;
    end
    if (ram_if.re) ram_if.dout <= fault_rd(int'(ram_if.rd_addr), mem[ram_if.rd_addr]);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Software run of the March sequence against the same fault behaviour.
  task automatic model_run(input logic [DW-1:0] p, output int exp_err, output int exp_fail);
    logic [DW-1:0] m [DEPTH];
    logic [DW-1:0] np;
    logic [DW-1:0] rd;
    bit            seen;
    np = ~p;
    exp_err = 0; exp_fail = 0; seen = 0;
    for (int i = 0; i < DEPTH; i++) m[i] = 8'h00;
    for (int a = 0; a < DEPTH; a++) begin
      m[a] = p;
      if (f_kind == 3 && a == f_src) m[f_dst] = p;
    end
    for (int a = 0; a < DEPTH; a++) begin
      rd = fault_rd(a, m[a]);
      if (rd != p) begin
        exp_err++;
        if (!seen) begin seen = 1; exp_fail = a; end
      end
      m[a] = np;
      if (f_kind == 3 && a == f_src) m[f_dst] = np;
    end
    for (int a = DEPTH - 1; a >= 0; a--) begin
      rd = fault_rd(a, m[a]);
      if (rd != np) begin
        exp_err++;
        if (!seen) begin seen = 1; exp_fail = a; end
      end
    end
  endtask

  // One complete test; start sampled at edge 0, observation in cycles 1..70.
  task automatic run_test(input string name, input logic [DW-1:0] p,
                          input bit inject, input bit start_in_done);
    int exp_err, exp_fail;
    int done_cnt, done_cyc, overlap, busy_err;
    int wr_n, rd_n, wr_err, rd_err;
    logic [DW-1:0] np;
    np = ~p;
    model_run(p, exp_err, exp_fail);
    done_cnt = 0; done_cyc = -1; overlap = 0; busy_err = 0;
    wr_n = 0; rd_n = 0; wr_err = 0; rd_err = 0;
    @(posedge clk); #1;
    pattern = p;
    start   = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int cyc = 1; cyc <= 70; cyc++) begin
      if (done) begin done_cnt++; done_cyc = cyc; end
      if (ram_if.we && ram_if.re) overlap++;
      if ((cyc <= 65) && !busy) busy_err++;
      if ((cyc >= 66) && busy) busy_err++;
      if ((cyc >= 65) && (ram_if.we || ram_if.re)) overlap++;
      if (ram_if.we) begin
        if (int'(ram_if.wr_addr) != (wr_n % DEPTH)) wr_err++;
        if (ram_if.din != ((wr_n < DEPTH) ? p : np)) wr_err++;
        wr_n++;
      end
      if (ram_if.re) begin
        if (int'(ram_if.rd_addr) != ((rd_n < DEPTH) ? rd_n : (2*DEPTH - 1 - rd_n))) rd_err++;
        rd_n++;
      end
      pattern = 8'($urandom);
      start = (inject && (cyc == 10 || cyc == 40)) || (start_in_done && cyc == 66);
      @(posedge clk); #1;
      start = 1'b0;
    end
    check({name, ".done_cyc"}, done_cyc, 66);
    check({name, ".done_cnt"}, done_cnt, 1);
    check({name, ".we_re"},    overlap, 0);
    check({name, ".busy"},     busy_err, 0);
    check({name, ".wr_n"},     wr_n, 2*DEPTH);
    check({name, ".rd_n"},     rd_n, 2*DEPTH);
    check({name, ".wr_seq"},   wr_err, 0);
    check({name, ".rd_seq"},   rd_err, 0);
    check({name, ".err"},      err_count, exp_err);
    check({name, ".fail"},     fail_addr, exp_fail);
    check({name, ".pass"},     pass, (exp_err == 0));
    $display("run %s pattern=%02h fault=%0d err=%0d fail=%0d pass=%0b", name, p,
             f_kind, err_count, fail_addr, pass);
  endtask

  task automatic check_all_zero(input string tag);
    check(tag, {ram_if.we, ram_if.re, ram_if.wr_addr, ram_if.rd_addr, ram_if.din,
                busy, done, pass, err_count, fail_addr}, 0);
  endtask

  initial begin
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1 check_all_zero("reset");
    @(negedge clk) rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 check("idle_busy", busy, 0);

    f_kind = 0;
    run_test("ideal_a5", 8'hA5, 0, 0);
    f_kind = 1; f_addr = 4; f_bit = 0;
    run_test("stuck4", 8'h00, 0, 0);
    f_kind = 3; f_src = 3; f_dst = 12;
    run_test("couple", 8'h5A, 0, 0);
    f_kind = 0;
    run_test("ign_start", 8'h3C, 1, 0);
    run_test("start_done", 8'hC3, 0, 1);

    for (int r = 0; r < 6; r++) begin
      f_kind = $urandom_range(0, 3);
      f_addr = $urandom_range(0, DEPTH - 1);
      f_bit  = $urandom_range(0, DW - 1);
      f_src  = $urandom_range(0, DEPTH - 1);
      f_dst  = (f_src + $urandom_range(1, DEPTH - 1)) % DEPTH;
      run_test($sformatf("rand%0d", r), 8'($urandom), (r % 2) == 1, 0);
    end

    // Reset during R1 with an error already recorded.
    f_kind = 1; f_addr = 2; f_bit = 3;
    @(posedge clk); #1;
    pattern = 8'h00;
    start   = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (29) @(posedge clk);
    #1;
    check("mid.busy", busy, 1);
    check("mid.err", err_count, 1);
    rst = 1'b0;
    #1 check_all_zero("mid.reset");
    @(negedge clk) rst = 1'b1;
    $display("reset applied in cycle 30, outputs cleared");
    f_kind = 0;
    run_test("after_rst", 8'h96, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
